// File: rtl/sdram_rr_arbiter.sv
// sdram_rr_arbiter: N-master round-robin arbiter in front of the SDRAM controller,
//   with a per-master cap on outstanding reads and response routing by master ID.
// Latency: grant -> registered command on sdram_* is 1 cycle; response -> m_* is 0 cycles.
// Backpressure: no grant while sdram_ready=0 (command regs and rr_ptr hold); a master at
//   MAX_OUTSTANDING reads is skipped for reads only, writes are never throttled.
// Optional macro ARB_HIGH_PRIO_M0_EN: master 0 always wins when eligible, others rotate.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   m_request/m_write/m_burst          per-master request and command flags
//   m_address/m_wdata/m_wstrb          packed per-master command fields
//   m_ready                            one-hot grant (combinational)
//   m_rvalid/m_complete                per-master response strobes (combinational)
//   m_raddress/m_rdata                 response address/data broadcast to all masters
//   sdram_request..sdram_wdata         registered command to the controller (ID 0 = idle)
//   sdram_ready                        controller accepts a command this cycle
//   sdram_rvalid/sdram_complete        response target ID (0 = none) and last-beat flag
//   sdram_raddress/sdram_rdata         response address/data from the controller
module sdram_rr_arbiter #(
  parameter int NUM_MASTERS     = 6,
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int ID_W           = $clog2(NUM_MASTERS + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS-1:0]        m_request,
  output logic [NUM_MASTERS-1:0]        m_ready,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS-1:0]        m_burst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [ADDR_W-1:0]             m_raddress,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_complete,
  output logic [ID_W-1:0]               sdram_request,
  input  logic                          sdram_ready,
  output logic [ADDR_W-1:0]             sdram_address,
  output logic                          sdram_write,
  output logic                          sdram_burst,
  output logic [DATA_W/8-1:0]           sdram_wstrb,
  output logic [DATA_W-1:0]             sdram_wdata,
  input  logic [ADDR_W-1:0]             sdram_raddress,
  input  logic [DATA_W-1:0]             sdram_rdata,
  input  logic [ID_W-1:0]               sdram_rvalid,
  input  logic                          sdram_complete
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int SUM_W = IDX_W + 1;
  localparam int SW    = DATA_W / 8;
  localparam int CNT_W = 3;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic                   grant_found;
  logic                   grant_vld;
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] rsp_hit;
  logic [NUM_MASTERS-1:0] rd_grant;
  logic [NUM_MASTERS-1:0] rd_done;
  logic [CNT_W-1:0]       cnt [NUM_MASTERS];

  // Eligibility, response decode and counter events per master.
  always_comb begin
    elig     = '0;
    rsp_hit  = '0;
    rd_grant = '0;
    rd_done  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i]     = m_request[i] & (m_write[i] | (cnt[i] < CNT_W'(MAX_OUTSTANDING)));
      rsp_hit[i]  = (sdram_rvalid == ID_W'(i + 1));
      rd_grant[i] = grant_vld & (grant_idx == IDX_W'(i)) & ~m_write[i];
      rd_done[i]  = rsp_hit[i] & sdram_complete;
    end
  end

  // Round-robin search starting at rr_ptr; index kept one bit wider so the wrap
  // compare sees the carry.
  always_comb begin
    logic [SUM_W-1:0] idx_w;
    idx_w       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef ARB_HIGH_PRIO_M0_EN
    if (elig[0]) begin
      grant_found = 1'b1;
    end else
`endif
    begin
      for (int off = 0; off < NUM_MASTERS; off++) begin
        idx_w = {1'b0, rr_ptr} + SUM_W'(off);
        if (idx_w >= SUM_W'(NUM_MASTERS)) idx_w = idx_w - SUM_W'(NUM_MASTERS);
        if (!grant_found && elig[idx_w]) begin
          grant_found = 1'b1;
          grant_idx   = idx_w[IDX_W-1:0];
        end
      end
    end
  end

  assign grant_vld = sdram_ready & grant_found;
  assign next_ptr  = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

  // Strobes are forced low during reset so masters never see a stale grant/response.
  assign m_ready    = (reset_n && grant_vld) ? (NUM_MASTERS'(1) << grant_idx) : '0;
  assign m_rvalid   = reset_n ? rsp_hit : '0;
  assign m_complete = (reset_n && sdram_complete) ? rsp_hit : '0;
  assign m_raddress = sdram_raddress;
  assign m_rdata    = sdram_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdram_request <= '0;
      sdram_address <= '0;
      sdram_write   <= 1'b0;
      sdram_burst   <= 1'b0;
      sdram_wstrb   <= '0;
      sdram_wdata   <= '0;
      rr_ptr        <= '0;
    end else if (sdram_ready) begin
      if (grant_found) begin
        sdram_request <= ID_W'(grant_idx) + ID_W'(1);
        sdram_address <= m_address[int'(grant_idx)*ADDR_W +: ADDR_W];
        sdram_write   <= m_write[grant_idx];
        sdram_burst   <= m_burst[grant_idx];
        sdram_wstrb   <= m_wstrb[int'(grant_idx)*SW +: SW];
        sdram_wdata   <= m_wdata[int'(grant_idx)*DATA_W +: DATA_W];
`ifdef ARB_HIGH_PRIO_M0_EN
        // The fixed-priority master does not take part in the rotation.
        if (grant_idx != '0) rr_ptr <= next_ptr;
`else
        rr_ptr <= next_ptr;
`endif
      end else begin
        // Idle command: address, burst and data hold to avoid needless toggling.
        sdram_request <= '0;
        sdram_write   <= 1'b0;
        sdram_wstrb   <= '0;
      end
    end
  end

  // Simultaneous issue and retire on one master cancel out; retire saturates at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MASTERS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (rd_grant[i] && !rd_done[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (rd_done[i] && !rd_grant[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// tb_sdram_rr_arbiter: table-driven bench for sdram_rr_arbiter with a command scoreboard.
// Each vector drives one cycle and checks m_ready/m_rvalid/m_complete combinationally;
// the expected registered command is queued and compared on the following cycle.
module tb_sdram_rr_arbiter;

  localparam int N  = 6;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_request, m_ready, m_write, m_burst, m_rvalid, m_complete;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [AW-1:0]   m_raddress, sdram_address, sdram_raddress;
  logic [DW-1:0]   m_rdata, sdram_wdata, sdram_rdata;
  logic [IW-1:0]   sdram_request, sdram_rvalid;
  logic            sdram_ready, sdram_write, sdram_burst, sdram_complete;
  logic [SW-1:0]   sdram_wstrb;

  always #5 clk = ~clk;

  sdram_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_request(m_request), .m_ready(m_ready), .m_write(m_write), .m_burst(m_burst),
    .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rvalid(m_rvalid), .m_raddress(m_raddress), .m_rdata(m_rdata),
    .m_complete(m_complete),
    .sdram_request(sdram_request), .sdram_ready(sdram_ready),
    .sdram_address(sdram_address), .sdram_write(sdram_write),
    .sdram_burst(sdram_burst), .sdram_wstrb(sdram_wstrb), .sdram_wdata(sdram_wdata),
    .sdram_raddress(sdram_raddress), .sdram_rdata(sdram_rdata),
    .sdram_rvalid(sdram_rvalid), .sdram_complete(sdram_complete)
  );

  typedef struct {
    string        name;
    bit           pre_rst;
    logic [N-1:0] req, wr;
    logic         rdy;
    logic [IW-1:0] rv;
    logic         cmpl;
    logic [N-1:0] exp_ready, exp_rvalid, exp_cmpl;
  } vec_t;

  typedef struct packed {
    logic [IW-1:0] req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          write;
    logic          burst;
  } cmd_t;

  localparam logic [N-1:0] BURST_PAT = 6'b101010;

  vec_t tbl[$];
  cmd_t sb[$];
  cmd_t last_exp;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [AW-1:0] addr_of(int i);
    logic [AW-1:0] a;
    a = 26'h0ABC00;
    return a + AW'(i * 16);
  endfunction

  function automatic logic [DW-1:0] wdata_of(int i);
    logic [DW-1:0] d;
    d = 32'hD000_0000;
    return d + DW'(i);
  endfunction

  function automatic logic [SW-1:0] wstrb_of(int i);
    return SW'(i + 1);
  endfunction

  function automatic vec_t mk(string n, bit pr, logic [N-1:0] req, logic [N-1:0] wr,
                              logic rdy, logic [IW-1:0] rv, logic c,
                              logic [N-1:0] er, logic [N-1:0] ev, logic [N-1:0] ec);
    vec_t v;
    v.name = n; v.pre_rst = pr; v.req = req; v.wr = wr; v.rdy = rdy; v.rv = rv;
    v.cmpl = c; v.exp_ready = er; v.exp_rvalid = ev; v.exp_cmpl = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_request = '1; m_write = '0; sdram_ready = 1'b1;
    sdram_rvalid = IW'(1); sdram_complete = 1'b1;
    #1;
    chk("rst.m_ready", m_ready, 0);
    chk("rst.m_rvalid", m_rvalid, 0);
    chk("rst.m_complete", m_complete, 0);
    chk("rst.sdram_request", sdram_request, 0);
    chk("rst.sdram_address", sdram_address, 0);
    chk("rst.sdram_wdata", sdram_wdata, 0);
    chk("rst.sdram_write", sdram_write, 0);
    m_request = '0; sdram_ready = 1'b0; sdram_rvalid = '0; sdram_complete = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    last_exp = '0;
    sb.push_back(last_exp);
  endtask

  task automatic step(vec_t v);
    cmd_t e, n;
    int   k;
    m_request = v.req; m_write = v.wr; sdram_ready = v.rdy;
    sdram_rvalid = v.rv; sdram_complete = v.cmpl;
    @(negedge clk);
    chk({v.name, ".m_ready"}, m_ready, v.exp_ready);
    chk({v.name, ".m_rvalid"}, m_rvalid, v.exp_rvalid);
    chk({v.name, ".m_complete"}, m_complete, v.exp_cmpl);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", v.name);
    end else begin
      e = sb.pop_front();
      chk({v.name, ".sdram_request"}, sdram_request, e.req);
      chk({v.name, ".sdram_address"}, sdram_address, e.addr);
      chk({v.name, ".sdram_wdata"}, sdram_wdata, e.wdata);
      chk({v.name, ".sdram_wstrb"}, sdram_wstrb, e.wstrb);
      chk({v.name, ".sdram_write"}, sdram_write, e.write);
      chk({v.name, ".sdram_burst"}, sdram_burst, e.burst);
    end
    n = last_exp;
    if (v.rdy) begin
      if (v.exp_ready != '0) begin
        k = 0;
        for (int i = 0; i < N; i++) if (v.exp_ready[i]) k = i;
        n.req = IW'(k + 1); n.addr = addr_of(k); n.wdata = wdata_of(k);
        n.wstrb = wstrb_of(k); n.write = v.wr[k]; n.burst = BURST_PAT[k];
      end else begin
        n.req = '0; n.write = 1'b0; n.wstrb = '0;
      end
    end
    last_exp = n;
    sb.push_back(n);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b1;
    m_request = '0; m_write = '0; sdram_ready = 1'b0;
    sdram_rvalid = '0; sdram_complete = 1'b0;
    m_burst = BURST_PAT;
    sdram_raddress = 26'h1234567;
    sdram_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW] = addr_of(i);
      m_wdata[i*DW +: DW]   = wdata_of(i);
      m_wstrb[i*SW +: SW]   = wstrb_of(i);
    end

    // Reads from masters 1 and 3.
    tbl.push_back(mk("rd13_a", 1, 6'b001010, 6'b000000, 1, 0, 0, 6'b000010, 0, 0));
    tbl.push_back(mk("rd13_b", 0, 6'b001000, 6'b000000, 1, 0, 0, 6'b001000, 0, 0));
    tbl.push_back(mk("rd13_idle", 0, 6'b000000, 6'b000000, 1, 0, 0, 6'b000000, 0, 0));
    // All masters writing: full rotation.
    tbl.push_back(mk("wr_all0", 1, 6'b111111, 6'b111111, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("wr_all1", 0, 6'b111111, 6'b111111, 1, 0, 0, 6'b000010, 0, 0));
    tbl.push_back(mk("wr_all2", 0, 6'b111111, 6'b111111, 1, 0, 0, 6'b000100, 0, 0));
    tbl.push_back(mk("wr_all3", 0, 6'b111111, 6'b111111, 1, 0, 0, 6'b001000, 0, 0));
    tbl.push_back(mk("wr_all4", 0, 6'b111111, 6'b111111, 1, 0, 0, 6'b010000, 0, 0));
    tbl.push_back(mk("wr_all5", 0, 6'b111111, 6'b111111, 1, 0, 0, 6'b100000, 0, 0));
    tbl.push_back(mk("wr_all6", 0, 6'b111111, 6'b111111, 1, 0, 0, 6'b000001, 0, 0));
    // Outstanding-read cap on master 2.
    tbl.push_back(mk("cap_rd1", 1, 6'b000100, 6'b000000, 1, 0, 0, 6'b000100, 0, 0));
    tbl.push_back(mk("cap_rd2", 0, 6'b000100, 6'b000000, 1, 0, 0, 6'b000100, 0, 0));
    tbl.push_back(mk("cap_block", 0, 6'b010100, 6'b010000, 1, 0, 0, 6'b010000, 0, 0));
    tbl.push_back(mk("cap_rsp", 0, 6'b000100, 6'b000000, 1, 3, 1, 6'b000000, 6'b000100, 6'b000100));
    tbl.push_back(mk("cap_reopen", 0, 6'b000100, 6'b000000, 1, 0, 0, 6'b000100, 0, 0));
    // Simultaneous issue/retire on master 0, invalid ID, sdram_ready low.
    tbl.push_back(mk("m0_rd1", 1, 6'b000001, 6'b000000, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("m0_both", 0, 6'b000001, 6'b000000, 1, 1, 1, 6'b000001, 6'b000001, 6'b000001));
    tbl.push_back(mk("m0_rd2", 0, 6'b000001, 6'b000000, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("m0_full", 0, 6'b000001, 6'b000000, 1, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk("bad_id7", 0, 6'b000000, 6'b000000, 1, 7, 1, 6'b000000, 0, 0));
    tbl.push_back(mk("m0_still", 0, 6'b000001, 6'b000000, 1, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk("m0_retire", 0, 6'b000001, 6'b000000, 1, 1, 1, 6'b000000, 6'b000001, 6'b000001));
    tbl.push_back(mk("m0_rd3", 0, 6'b000001, 6'b000000, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("not_rdy", 0, 6'b000110, 6'b000110, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk("rdy_again", 0, 6'b000110, 6'b000110, 1, 0, 0, 6'b000010, 0, 0));
    tbl.push_back(mk("beat_nc", 0, 6'b000100, 6'b000100, 1, 1, 0, 6'b000100, 6'b000001, 0));
    tbl.push_back(mk("m0_capped", 0, 6'b000001, 6'b000000, 1, 0, 0, 6'b000000, 0, 0));
    // Masters 0 and 1 writing continuously, then master 0 drops.
`ifdef ARB_HIGH_PRIO_M0_EN
    tbl.push_back(mk("prio_1", 1, 6'b000011, 6'b000011, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("prio_2", 0, 6'b000011, 6'b000011, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("prio_3", 0, 6'b000011, 6'b000011, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("prio_4", 0, 6'b000011, 6'b000011, 1, 0, 0, 6'b000001, 0, 0));
`else
    tbl.push_back(mk("prio_1", 1, 6'b000011, 6'b000011, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("prio_2", 0, 6'b000011, 6'b000011, 1, 0, 0, 6'b000010, 0, 0));
    tbl.push_back(mk("prio_3", 0, 6'b000011, 6'b000011, 1, 0, 0, 6'b000001, 0, 0));
    tbl.push_back(mk("prio_4", 0, 6'b000011, 6'b000011, 1, 0, 0, 6'b000010, 0, 0));
`endif
    tbl.push_back(mk("prio_m1", 0, 6'b000010, 6'b000010, 1, 0, 0, 6'b000010, 0, 0));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pre_rst) do_reset();
      step(tbl[i]);
    end

    // Response data/address are broadcast straight through.
    chk("pass.m_raddress", m_raddress, 26'h1234567);
    chk("pass.m_rdata", m_rdata, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a cycle drops the pending command.
    m_request = 6'b000100; m_write = 6'b000100; sdram_ready = 1'b1;
    sdram_rvalid = '0; sdram_complete = 1'b0;
    @(posedge clk); #1;
    chk("arst.cmd_before", sdram_request, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.sdram_request", sdram_request, 0);
    chk("arst.sdram_address", sdram_address, 0);
    chk("arst.m_ready", m_ready, 0);
    @(posedge clk); #1;
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
